fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 21 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemRdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one output slot feeding IF/ID and one skid slot that
// absorbs a fetch completing while the output slot is held by a stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch,
  input  logic [31:0]  branchTarget,
  fetch_unit_if.master imem,
  output logic [31:0]  preInstruction,
  output logic [31:0]  pcPlus4,
  output logic         ifIdWrIn,
  output logic         endProgram
);

  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e      stateQ;
  logic [31:0] pcQ;
  logic [31:0] outInstrQ;
  logic [31:0] outPc4Q;
  logic        outValidQ;
  logic [31:0] skidInstrQ;
  logic [31:0] skidPc4Q;
  logic        skidValidQ;
  logic        haltPendingQ;  // halt word fetched; stop requesting until flushed

  logic        fire;
  logic        consume;
  logic [31:0] pcNext;

  // Request whenever there is room downstream and no halt is in the pipe.
  assign imem.imemReq  = !reset && (stateQ == StFetch) && !skidValidQ && !haltPendingQ;
  assign imem.imemAddr = pcQ;

  assign fire    = imem.imemReq && imem.imemReady;
  assign consume = ifIdWrIn;
  assign pcNext  = pcQ + 32'd4;

  assign ifIdWrIn       = !reset && (stateQ == StFetch) && outValidQ && !stall;
  assign preInstruction = outInstrQ;
  assign pcPlus4        = outPc4Q;

  // PC, slot and FSM update; branch flushes everything, halt freezes the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ       <= StFetch;
      pcQ          <= RESET_PC;
      outInstrQ    <= '0;
      outPc4Q      <= '0;
      outValidQ    <= 1'b0;
      skidInstrQ   <= '0;
      skidPc4Q     <= '0;
      skidValidQ   <= 1'b0;
      haltPendingQ <= 1'b0;
      endProgram   <= 1'b0;
    end else if (stateQ == StFetch) begin
      if (consume && (outInstrQ == HALT_WORD)) begin
        endProgram <= 1'b1;
        stateQ     <= StHalted;
      end
      if (branch) begin
        // Any response completing this cycle is dropped by not capturing it.
        pcQ          <= branchTarget;
        outValidQ    <= 1'b0;
        skidValidQ   <= 1'b0;
        haltPendingQ <= 1'b0;
      end else begin
        if (fire) begin
          pcQ <= pcNext;
          if (imem.imemRdata == HALT_WORD) begin
            haltPendingQ <= 1'b1;
          end
        end
        if (consume) begin
          if (skidValidQ) begin
            // Skid is older than anything in flight; it always goes first.
            outInstrQ  <= skidInstrQ;
            outPc4Q    <= skidPc4Q;
            skidValidQ <= 1'b0;
          end else if (fire) begin
            outInstrQ <= imem.imemRdata;
            outPc4Q   <= pcNext;
          end else begin
            outValidQ <= 1'b0;
          end
        end else if (fire) begin
          if (!outValidQ) begin
            outInstrQ <= imem.imemRdata;
            outPc4Q   <= pcNext;
            outValidQ <= 1'b1;
          end else begin
            skidInstrQ <= imem.imemRdata;
            skidPc4Q   <= pcNext;
            skidValidQ <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/skid, branch flush, wait states,
// halt, PC wrap and reset in the middle of a wait.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [31:0] branchTarget;
  logic [31:0] preInstruction;
  logic [31:0] pcPlus4;
  logic        ifIdWrIn;
  logic        endProgram;

  logic        readyOn;
  logic        streamMode;
  logic        haltMode;

  int nTests = 0;
  int nFail  = 0;

  logic [63:0] wq[$];  // {preInstruction, pcPlus4} for every IF/ID write

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branchTarget  (branchTarget),
    .imem          (bus.master),
    .preInstruction(preInstruction),
    .pcPlus4       (pcPlus4),
    .ifIdWrIn      (ifIdWrIn),
    .endProgram    (endProgram)
  );

  always #5 clk = ~clk;

  // Memory model: a tag derived from the address, with optional fixed words.
  always_comb begin
    bus.imemReady = readyOn;
    bus.imemRdata = bus.imemAddr ^ 32'hA5A5_0000;
    if (streamMode && bus.imemAddr < 32'hC) begin
      bus.imemRdata = 32'h11 * ((bus.imemAddr >> 2) + 32'd1);
    end
    if (haltMode && bus.imemAddr == 32'hC) begin
      bus.imemRdata = 32'hFFFF_FFFF;
    end
  end

  always @(negedge clk) begin
    if (!reset && ifIdWrIn) wq.push_back({preInstruction, pcPlus4});
  end

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; stall = 1'b0; branch = 1'b0; branchTarget = '0; readyOn = 1'b1;
    step();
    step();
    reset = 1'b0;
    wq.delete();
  endtask

  task automatic test_reset();
    streamMode = 1'b0; haltMode = 1'b0;
    reset = 1'b1; stall = 1'b0; branch = 1'b0; branchTarget = '0; readyOn = 1'b1;
    step();
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b0 || ifIdWrIn !== 1'b0) begin
      nFail++; $display("FAIL reset_ctrl: req=%b wr=%b want 0 0", bus.imemReq, ifIdWrIn);
    end
    nTests++;
    if (endProgram !== 1'b0 || preInstruction !== 32'h0 || pcPlus4 !== 32'h0) begin
      nFail++;
      $display("FAIL reset_regs: end=%b instr=%h pc4=%h want 0 0 0",
               endProgram, preInstruction, pcPlus4);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
      nFail++; $display("FAIL reset_first_req: req=%b addr=%h want 1 0", bus.imemReq, bus.imemAddr);
    end
  endtask

  task automatic test_stream();
    logic [63:0] exp [3];
    streamMode = 1'b1; haltMode = 1'b0;
    doReset();
    @(negedge clk);
    nTests++;
    if (ifIdWrIn !== 1'b0) begin
      nFail++; $display("FAIL stream_no_early_wr: got %b want 0", ifIdWrIn);
    end
    step();
    @(negedge clk);
    nTests++;
    if (ifIdWrIn !== 1'b1 || preInstruction !== 32'h11 || pcPlus4 !== 32'h4) begin
      nFail++;
      $display("FAIL stream_first: wr=%b instr=%h pc4=%h want 1 11 4",
               ifIdWrIn, preInstruction, pcPlus4);
    end
    repeat (3) step();
    exp[0] = {32'h11, 32'h4}; exp[1] = {32'h22, 32'h8}; exp[2] = {32'h33, 32'hC};
    for (int i = 0; i < 3; i++) begin
      nTests++;
      if (wq.size() <= i || wq[i] !== exp[i]) begin
        nFail++; $display("FAIL stream_order[%0d]: got %h want %h", i, wq[i], exp[i]);
      end
    end
    streamMode = 1'b0;
  endtask

  task automatic test_stall_skid();
    logic [63:0] exp [5];
    doReset();
    step();               // C1: write word@0, fetch word@4
    step();               // C2
    stall = 1'b1;
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b1 || ifIdWrIn !== 1'b0) begin
      nFail++; $display("FAIL stall_c2: req=%b wr=%b want 1 0", bus.imemReq, ifIdWrIn);
    end
    step();               // C3: skid holds word@8
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b0) begin
      nFail++; $display("FAIL stall_req_drop: req=%b want 0", bus.imemReq);
    end
    step();               // C4
    step();               // C5
    stall = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      exp[i] = {tagOf(32'(i * 4)), 32'(i * 4 + 4)};
      nTests++;
      if (wq.size() <= i || wq[i] !== exp[i]) begin
        nFail++; $display("FAIL stall_order[%0d]: got %h want %h", i, wq[i], exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [63:0] exp [4];
    doReset();
    step();               // C1
    step();               // C2
    stall = 1'b1;
    step();               // C3: out=word@4, skid=word@8
    branch = 1'b1; branchTarget = 32'h100;
    step();               // C4
    branch = 1'b0; stall = 1'b0;
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100 || ifIdWrIn !== 1'b0) begin
      nFail++;
      $display("FAIL branch_redirect: req=%b addr=%h wr=%b want 1 100 0",
               bus.imemReq, bus.imemAddr, ifIdWrIn);
    end
    step();               // C5: branch again while a fetch at 0x104 completes
    branch = 1'b1; branchTarget = 32'h40;
    @(negedge clk);
    nTests++;
    if (ifIdWrIn !== 1'b1 || pcPlus4 !== 32'h104) begin
      nFail++; $display("FAIL branch_cycle_wr: wr=%b pc4=%h want 1 104", ifIdWrIn, pcPlus4);
    end
    step();               // C6
    branch = 1'b0;
    @(negedge clk);
    nTests++;
    if (bus.imemAddr !== 32'h40) begin
      nFail++; $display("FAIL branch2_addr: addr=%h want 40", bus.imemAddr);
    end
    repeat (3) step();
    exp[0] = {tagOf(32'h0), 32'h4};
    exp[1] = {tagOf(32'h100), 32'h104};
    exp[2] = {tagOf(32'h40), 32'h44};
    exp[3] = {tagOf(32'h44), 32'h48};
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (wq.size() <= i || wq[i] !== exp[i]) begin
        nFail++; $display("FAIL branch_order[%0d]: got %h want %h", i, wq[i], exp[i]);
      end
    end
  endtask

  task automatic test_wait();
    logic [63:0] exp [3];
    doReset();
    step();               // C1
    step();               // C2
    readyOn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stall = (c == 1 || c == 2);  // stall over an empty slot must not matter
      @(negedge clk);
      nTests++;
      if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h8) begin
        nFail++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h want 1 8", c, bus.imemReq, bus.imemAddr);
      end
      if (c > 0) begin
        nTests++;
        if (ifIdWrIn !== 1'b0) begin
          nFail++; $display("FAIL wait_no_wr[%0d]: wr=%b want 0", c, ifIdWrIn);
        end
      end
      step();
    end
    stall = 1'b0;
    readyOn = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      exp[i] = {tagOf(32'(i * 4)), 32'(i * 4 + 4)};
      nTests++;
      if (wq.size() <= i || wq[i] !== exp[i]) begin
        nFail++; $display("FAIL wait_order[%0d]: got %h want %h", i, wq[i], exp[i]);
      end
    end
  endtask

  task automatic test_halt();
    haltMode = 1'b1;
    doReset();
    repeat (4) step();    // C4: halt word sits in the output slot
    @(negedge clk);
    nTests++;
    if (ifIdWrIn !== 1'b1 || preInstruction !== 32'hFFFF_FFFF || endProgram !== 1'b0 ||
        bus.imemReq !== 1'b0) begin
      nFail++;
      $display("FAIL halt_write: wr=%b instr=%h end=%b req=%b want 1 ffffffff 0 0",
               ifIdWrIn, preInstruction, endProgram, bus.imemReq);
    end
    step();               // C5
    branch = 1'b1; branchTarget = 32'h100;
    @(negedge clk);
    nTests++;
    if (endProgram !== 1'b1 || bus.imemReq !== 1'b0 || ifIdWrIn !== 1'b0) begin
      nFail++;
      $display("FAIL halt_set: end=%b req=%b wr=%b want 1 0 0", endProgram, bus.imemReq, ifIdWrIn);
    end
    step();
    branch = 1'b0;
    repeat (2) step();
    @(negedge clk);
    nTests++;
    if (endProgram !== 1'b1 || bus.imemReq !== 1'b0 || bus.imemAddr !== 32'h10) begin
      nFail++;
      $display("FAIL halt_branch_ignored: end=%b req=%b addr=%h want 1 0 10",
               endProgram, bus.imemReq, bus.imemAddr);
    end
    haltMode = 1'b0;
    doReset();
    @(negedge clk);
    nTests++;
    if (endProgram !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin
      nFail++;
      $display("FAIL halt_reset: end=%b req=%b addr=%h want 0 1 0",
               endProgram, bus.imemReq, bus.imemAddr);
    end
  endtask

  task automatic test_wrap_reset();
    doReset();
    branch = 1'b1; branchTarget = 32'hFFFF_FFFC;
    step();               // C1
    branch = 1'b0;
    @(negedge clk);
    nTests++;
    if (bus.imemAddr !== 32'hFFFF_FFFC || bus.imemReq !== 1'b1) begin
      nFail++; $display("FAIL wrap_req: addr=%h req=%b want fffffffc 1", bus.imemAddr, bus.imemReq);
    end
    step();               // C2
    @(negedge clk);
    nTests++;
    if (bus.imemAddr !== 32'h0 || pcPlus4 !== 32'h0 || preInstruction !== tagOf(32'hFFFF_FFFC)) begin
      nFail++;
      $display("FAIL wrap_next: addr=%h pc4=%h instr=%h want 0 0 %h",
               bus.imemAddr, pcPlus4, preInstruction, tagOf(32'hFFFF_FFFC));
    end
    step();               // C3: waiting at 0x4
    readyOn = 1'b0;
    step();               // C4: reset while the response finally arrives
    reset = 1'b1; readyOn = 1'b1;
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b0 || ifIdWrIn !== 1'b0) begin
      nFail++; $display("FAIL midreset_ctrl: req=%b wr=%b want 0 0", bus.imemReq, ifIdWrIn);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    nTests++;
    if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0 || ifIdWrIn !== 1'b0) begin
      nFail++;
      $display("FAIL midreset_refetch: req=%b addr=%h wr=%b want 1 0 0",
               bus.imemReq, bus.imemAddr, ifIdWrIn);
    end
    step();
    @(negedge clk);
    nTests++;
    if (ifIdWrIn !== 1'b1 || preInstruction !== tagOf(32'h0) || pcPlus4 !== 32'h4) begin
      nFail++;
      $display("FAIL midreset_first: wr=%b instr=%h pc4=%h want 1 %h 4",
               ifIdWrIn, preInstruction, pcPlus4, tagOf(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_branch();
    test_wait();
    test_halt();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
